// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_access_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_W         = 30;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned WAIT_W         = 8;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Little-endian lane enables; the reserved size behaves as a word.
    function automatic logic [BE_W-1:0] lane_enable(access_size_e size, logic [1:0] off);
        case (size)
            SIZE_BYTE: lane_enable = BE_W'(4'b0001 << off);
            SIZE_HALF: lane_enable = off[1] ? 4'b1100 : 4'b0011;
            default:   lane_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_replicate(access_size_e size, logic [DATA_W-1:0] data);
        case (size)
            SIZE_BYTE: store_replicate = {4{data[7:0]}};
            SIZE_HALF: store_replicate = {2{data[15:0]}};
            default:   store_replicate = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// Selects the addressed lane(s) of a read word and zero/sign-extends to 32 bits.
module mem_load_formatter
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        byte_off,
    input  access_size_e      size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = read_data[{byte_off, 3'b000} +: 8];
        lane_half = read_data[{byte_off[1], 4'b0000} +: 16];
        load_data = read_data;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default:   load_data = read_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one request per aligned load/store,
// stalls the pipeline until ack or timeout, and formats load results.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_isLoad,
    input  logic              mem_isStore,
    input  logic [1:0]        mem_accessSize,
    input  logic              mem_isUnsigned,
    input  logic [DATA_W-1:0] mem_aluOutput,
    input  logic [DATA_W-1:0] mem_storeData,
    output logic              dmem_req,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_byteEnable,
    output logic [DATA_W-1:0] dmem_writeData,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_readData,
    output logic [DATA_W-1:0] mem_memoryData,
    output logic              mem_stall,
    output logic              mem_misaligned,
    output logic              mem_busError
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                req_q, req_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;
    logic                bus_err_q, bus_err_d;
    logic [1:0]          off_q, off_d;
    access_size_e        size_q, size_d;
    logic                uns_q, uns_d;
    logic                is_load_q, is_load_d;

    access_size_e        size_c;
    logic                access_c;
    logic                misaligned_c;
    logic                start_c;
    logic                timeout_c;
    logic [DATA_W-1:0]   load_data_c;

    assign size_c    = access_size_e'(mem_accessSize);
    assign access_c  = mem_valid & (mem_isLoad | mem_isStore);
    assign start_c   = (state_q == ST_IDLE) & access_c & ~misaligned_c;
    // The 255th BUSY cycle without an ack is the last one.
    assign timeout_c = (state_q == ST_BUSY) & ~dmem_ack & (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (size_c)
            SIZE_BYTE: misaligned_c = 1'b0;
            SIZE_HALF: misaligned_c = mem_aluOutput[0];
            default:   misaligned_c = (mem_aluOutput[1:0] != 2'b00);
        endcase
    end

    mem_load_formatter u_fmt (
        .read_data   (dmem_readData),
        .byte_off    (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            mdata_q   <= '0;
            bus_err_q <= 1'b0;
            off_q     <= '0;
            size_q    <= SIZE_BYTE;
            uns_q     <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            mdata_q   <= mdata_d;
            bus_err_q <= bus_err_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_c) state_d = ST_BUSY;
            ST_BUSY: if (dmem_ack || timeout_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_d    = wait_q;
        req_d     = 1'b0;
        write_d   = write_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        mdata_d   = mdata_q;
        bus_err_d = 1'b0;
        off_d     = off_q;
        size_d    = size_q;
        uns_d     = uns_q;
        is_load_d = is_load_q;
        mem_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    wait_d    = '0;
                    write_d   = mem_isStore;
                    addr_d    = mem_aluOutput[DATA_W-1:2];
                    be_d      = lane_enable(size_c, mem_aluOutput[1:0]);
                    wdata_d   = store_replicate(size_c, mem_storeData);
                    off_d     = mem_aluOutput[1:0];
                    size_d    = size_c;
                    uns_d     = mem_isUnsigned;
                    is_load_d = ~mem_isStore;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (dmem_ack) begin
                    if (is_load_q) mdata_d = load_data_c;
                end else if (timeout_c) begin
                    bus_err_d = 1'b1;
                    mdata_d   = '0;
                end else begin
                    req_d  = 1'b1;
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign dmem_req        = req_q;
    assign dmem_write      = write_q;
    assign dmem_addr       = addr_q;
    assign dmem_byteEnable = be_q;
    assign dmem_writeData  = wdata_q;
    assign mem_memoryData  = mdata_q;
    assign mem_busError    = bus_err_q;
    assign mem_misaligned  = access_c & misaligned_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus timeout/reset sequences.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, mem_isLoad, mem_isStore, mem_isUnsigned;
    logic [1:0]  mem_accessSize;
    logic [31:0] mem_aluOutput, mem_storeData;
    logic        dmem_req, dmem_write, dmem_ack;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_byteEnable;
    logic [31:0] dmem_writeData, dmem_readData, mem_memoryData;
    logic        mem_stall, mem_misaligned, mem_busError;

    int errors = 0;
    int checks = 0;

    mem_access_unit dut (
        .clock           (clock),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_isLoad      (mem_isLoad),
        .mem_isStore     (mem_isStore),
        .mem_accessSize  (mem_accessSize),
        .mem_isUnsigned  (mem_isUnsigned),
        .mem_aluOutput   (mem_aluOutput),
        .mem_storeData   (mem_storeData),
        .dmem_req        (dmem_req),
        .dmem_write      (dmem_write),
        .dmem_addr       (dmem_addr),
        .dmem_byteEnable (dmem_byteEnable),
        .dmem_writeData  (dmem_writeData),
        .dmem_ack        (dmem_ack),
        .dmem_readData   (dmem_readData),
        .mem_memoryData  (mem_memoryData),
        .mem_stall       (mem_stall),
        .mem_misaligned  (mem_misaligned),
        .mem_busError    (mem_busError)
    );

    always #5 clock = ~clock;

    // kind: 0 = aligned access, 1 = misaligned, 2 = no access
    typedef struct {
        logic        valid, ld, st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, sdata;
        int          delay;
        logic [31:0] rdata;
        int          kind;
        logic [29:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_wr;
        logic [31:0] exp_wdata, exp_mdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_isLoad = 1'b0; mem_isStore = 1'b0;
        mem_accessSize = 2'b00; mem_isUnsigned = 1'b0;
        mem_aluOutput = '0; mem_storeData = '0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int stalls;
        string p;
        p = $sformatf("v%0d", i);
        @(negedge clock);
        mem_valid = v.valid; mem_isLoad = v.ld; mem_isStore = v.st;
        mem_accessSize = v.size; mem_isUnsigned = v.uns;
        mem_aluOutput = v.addr; mem_storeData = v.sdata;
        #1;
        check({p, "_misaligned"}, 32'(mem_misaligned), 32'(v.kind == 1));
        if (v.kind != 0) begin
            check({p, "_stall_idle"}, 32'(mem_stall), 32'd0);
            repeat (3) begin
                @(negedge clock);
                check({p, "_no_req"}, 32'(dmem_req), 32'd0);
            end
            check({p, "_mdata"}, mem_memoryData, v.exp_mdata);
            idle_inputs();
            return;
        end
        stalls = int'(mem_stall);
        for (int c = 1; c <= v.delay; c++) begin
            @(negedge clock);
            stalls += int'(mem_stall);
            check({p, "_req_busy"}, 32'(dmem_req), 32'd1);
            if (c == v.delay) begin
                dmem_ack = 1'b1;
                dmem_readData = v.rdata;
            end
        end
        check({p, "_addr"}, 32'(dmem_addr), 32'(v.exp_addr));
        check({p, "_be"}, 32'(dmem_byteEnable), 32'(v.exp_be));
        check({p, "_write"}, 32'(dmem_write), 32'(v.exp_wr));
        check({p, "_wdata"}, dmem_writeData, v.exp_wdata);
        @(negedge clock);
        dmem_ack = 1'b0;
        dmem_readData = 32'h0BAD_0BAD;
        check({p, "_stall_cycles"}, 32'(stalls), 32'(v.delay + 1));
        check({p, "_done_stall"}, 32'(mem_stall), 32'd0);
        check({p, "_done_req"}, 32'(dmem_req), 32'd0);
        check({p, "_mdata"}, mem_memoryData, v.exp_mdata);
        check({p, "_buserr"}, 32'(mem_busError), 32'd0);
        idle_inputs();
        @(negedge clock);
        check({p, "_idle_req"}, 32'(dmem_req), 32'd0);
    endtask

    task automatic timeout_seq(input bit with_ack);
        int cnt;
        string p;
        p = with_ack ? "tmo_ack" : "tmo";
        @(negedge clock);
        mem_valid = 1'b1; mem_isLoad = 1'b1; mem_accessSize = 2'b10; mem_aluOutput = 32'h200;
        #1;
        check({p, "_stall_idle"}, 32'(mem_stall), 32'd1);
        cnt = 0;
        @(negedge clock);
        while (dmem_req === 1'b1 && cnt < 400) begin
            cnt++;
            if (with_ack && cnt == 255) begin
                dmem_ack = 1'b1;
                dmem_readData = 32'h1357_9BDF;
            end
            @(negedge clock);
        end
        dmem_ack = 1'b0;
        check({p, "_busy_cycles"}, 32'(cnt), 32'd255);
        check({p, "_buserr"}, 32'(mem_busError), with_ack ? 32'd0 : 32'd1);
        check({p, "_mdata"}, mem_memoryData, with_ack ? 32'h1357_9BDF : 32'h0);
        check({p, "_done_stall"}, 32'(mem_stall), 32'd0);
        idle_inputs();
        @(negedge clock);
        check({p, "_buserr_pulse"}, 32'(mem_busError), 32'd0);
        check({p, "_idle_req"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          vld  ld   st   size   uns  addr          sdata         dly rdata         kind eaddr     ebe      ewr  ewdata        emdata
        vecs[0]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,32'h0000_0100,32'h0,        2, 32'hDEAD_BEEF,0, 30'h40,   4'b1111,1'b0,32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0000_0103,32'h0,        1, 32'h8011_2233,0, 30'h40,   4'b1000,1'b0,32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1,1'b1,1'b0,2'b00,1'b1,32'h0000_0103,32'h0,        1, 32'h8011_2233,0, 30'h40,   4'b1000,1'b0,32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1,1'b0,1'b1,2'b01,1'b0,32'h0000_0022,32'h0000_ABCD,1, 32'h1234_5678,0, 30'h08,   4'b1100,1'b1,32'hABCD_ABCD,32'h0000_0080};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'b10,1'b0,32'h0000_0101,32'h0,        0, 32'h0,        1, 30'h0,    4'b0000,1'b0,32'h0,        32'h0000_0080};
        vecs[5]  = '{1'b1,1'b1,1'b0,2'b01,1'b0,32'h0000_0002,32'h0,        3, 32'h8001_1234,0, 30'h00,   4'b1100,1'b0,32'h0,        32'hFFFF_8001};
        vecs[6]  = '{1'b1,1'b0,1'b1,2'b00,1'b0,32'h0000_0041,32'h1234_565A,1, 32'h0,        0, 30'h10,   4'b0010,1'b1,32'h5A5A_5A5A,32'hFFFF_8001};
        vecs[7]  = '{1'b1,1'b1,1'b0,2'b01,1'b1,32'h0000_0010,32'h0,        2, 32'h1234_F00D,0, 30'h04,   4'b0011,1'b0,32'h0,        32'h0000_F00D};
        vecs[8]  = '{1'b1,1'b1,1'b0,2'b01,1'b0,32'h0000_0013,32'h0,        0, 32'h0,        1, 30'h0,    4'b0000,1'b0,32'h0,        32'h0000_F00D};
        vecs[9]  = '{1'b1,1'b1,1'b0,2'b11,1'b0,32'h0000_0008,32'h0,        1, 32'hCAFE_F00D,0, 30'h02,   4'b1111,1'b0,32'h0,        32'hCAFE_F00D};
        vecs[10] = '{1'b1,1'b1,1'b1,2'b10,1'b0,32'h0000_0004,32'h1122_3344,1, 32'hFFFF_FFFF,0, 30'h01,   4'b1111,1'b1,32'h1122_3344,32'hCAFE_F00D};
        vecs[11] = '{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0000_0000,32'h0,        1, 32'h0000_007F,0, 30'h00,   4'b0001,1'b0,32'h0,        32'h0000_007F};
        vecs[12] = '{1'b0,1'b1,1'b0,2'b10,1'b0,32'h0000_0101,32'h0,        0, 32'h0,        2, 30'h0,    4'b0000,1'b0,32'h0,        32'h0000_007F};
        vecs[13] = '{1'b1,1'b1,1'b0,2'b00,1'b0,32'h0000_0002,32'h0,        1, 32'h00FE_0000,0, 30'h00,   4'b0100,1'b0,32'h0,        32'hFFFF_FFFE};

        idle_inputs();
        dmem_ack = 1'b0;
        dmem_readData = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_write", 32'(dmem_write), 32'd0);
        check("rst_addr", 32'(dmem_addr), 32'd0);
        check("rst_be", 32'(dmem_byteEnable), 32'd0);
        check("rst_wdata", dmem_writeData, 32'd0);
        check("rst_mdata", mem_memoryData, 32'd0);
        check("rst_buserr", 32'(mem_busError), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Ack while idle must be ignored.
        @(negedge clock);
        dmem_ack = 1'b1;
        dmem_readData = 32'h5555_AAAA;
        @(negedge clock);
        dmem_ack = 1'b0;
        check("idle_ack_mdata", mem_memoryData, 32'hFFFF_FFFE);
        check("idle_ack_req", 32'(dmem_req), 32'd0);
        check("idle_ack_stall", 32'(mem_stall), 32'd0);

        timeout_seq(1'b0);
        timeout_seq(1'b1);

        // Reset in the second BUSY cycle, then a late ack.
        @(negedge clock);
        mem_valid = 1'b1; mem_isLoad = 1'b1; mem_accessSize = 2'b10; mem_aluOutput = 32'h100;
        @(negedge clock);
        check("rstb_req_busy1", 32'(dmem_req), 32'd1);
        @(negedge clock);
        check("rstb_req_busy2", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        dmem_ack = 1'b1;
        dmem_readData = 32'hFFFF_FFFF;
        #1;
        check("rstb_req", 32'(dmem_req), 32'd0);
        check("rstb_mdata", mem_memoryData, 32'd0);
        check("rstb_stall", 32'(mem_stall), 32'd0);
        check("rstb_addr", 32'(dmem_addr), 32'd0);
        @(negedge clock);
        dmem_ack = 1'b0;
        check("rstb_late_ack_mdata", mem_memoryData, 32'd0);
        check("rstb_late_ack_req", 32'(dmem_req), 32'd0);
        check("rstb_late_ack_buserr", 32'(mem_busError), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
